ring_clock_engine: RTL and testbench



---
 rtl/ring_clock_engine_if.sv | 36 +++
 rtl/ring_clock_engine.sv | 220 ++++++++++++++++++++++
 tb/tb_ring_clock_engine.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ring_clock_engine_if.sv
// Ring clock engine bus: front-panel inputs,
// ring select, hand colour and time outputs.
interface ring_clock_engine_if #(
  parameter int RING_LEDS = 60,
  parameter int HOURS     = 12
);
  logic                     fast_mode;
  logic                     adv_min;
  logic                     adv_hour;
  logic                     zero_sec;
  logic [RING_LEDS-1:0]     leds;
  logic [7:0]               int_r;
  logic [7:0]               int_g;
  logic [7:0]               int_b;
  logic [1:0]               hand_sel;
  logic [5:0]               second;
  logic [5:0]               minute;
  logic [$clog2(HOURS)-1:0] hour;
  logic                     tick;

  modport master (
    output fast_mode, adv_min,
    output adv_hour, zero_sec,
    input  leds, int_r, int_g, int_b,
    input  hand_sel, second, minute,
    input  hour, tick
  );

  modport slave (
    input  fast_mode, adv_min,
    input  adv_hour, zero_sec,
    output leds, int_r, int_g, int_b,
    output hand_sel, second, minute,
    output hour, tick
  );
endinterface

// File: rtl/ring_clock_engine.sv
// Timekeeping plus hand multiplexer for the
// LED-ring clock: prescaler, h:m:s, ring select.
module ring_clock_engine #(
  parameter int          CLK_HZ       = 16000000,
  parameter int          FAST_DIV     = 128,
  parameter int          RING_LEDS    = 60,
  parameter int          HOURS        = 12,
  parameter int          SLOT_CYCLES  = 2048,
  parameter int          BLANK_CYCLES = 16,
  parameter logic [23:0] COL_SEC      = 24'h8C0CFF,
  parameter logic [23:0] COL_MIN      = 24'hFF4019,
  parameter logic [23:0] COL_HOUR     = 24'hC8C800
) (
  input logic clk_16mhz,
  input logic rst_n,
  ring_clock_engine_if.slave bus
);

  localparam int PW = $clog2(CLK_HZ + 1);
  localparam int HW = $clog2(HOURS);
  localparam int SW = (SLOT_CYCLES > 1) ?
                      $clog2(SLOT_CYCLES) : 1;

  localparam logic [PW-1:0] SLOW_LIM =
    PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] FAST_LIM =
    PW'(CLK_HZ / FAST_DIV - 1);
  localparam logic [RING_LEDS-1:0] ONE =
    RING_LEDS'(1);

  logic [1:0] rsync;
  logic       run;
  logic [1:0] fsync;
  logic       fast_s;
  // bit 0 adv_min, bit 1 adv_hour, bit 2 zero_sec
  logic [2:0] es1;
  logic [2:0] es2;
  logic [2:0] eprev;
  logic [2:0] ev;

  logic [PW-1:0] presc;
  logic [5:0]    secs;
  logic [5:0]    mins;
  logic [HW-1:0] hrs;
  logic          pend;
  logic          tick_r;

  logic [PW-1:0] lim;
  logic          hit;
  logic          due;
  logic [5:0]    sec_nx;
  logic [5:0]    min_nx;
  logic [HW-1:0] hr_nx;
  logic [PW-1:0] n_presc;
  logic [5:0]    n_sec;
  logic [5:0]    n_min;
  logic [HW-1:0] n_hr;
  logic          n_pend;
  logic          n_tick;

  logic [SW-1:0] slot_cnt;
  logic [1:0]    slot_idx;
  logic          lit;
  logic [31:0]   sec_pos;
  logic [31:0]   min_pos;
  logic [31:0]   hr_pos;
  logic [31:0]   pos;
  logic [23:0]   col;

  logic [RING_LEDS-1:0] leds_q;
  logic [23:0]          col_q;
  logic [1:0]           sel_q;

  assign run    = rsync[1];
  assign fast_s = fsync[1];
  assign ev     = es2 & ~eprev;

  // Release of reset is retimed so counting starts cleanly
  always_ff @(posedge clk_16mhz or negedge rst_n) begin
    if (!rst_n) begin
      rsync <= '0;
    end else begin
      rsync <= {rsync[0], 1'b1};
    end
  end

  // Two-flop synchronisers and rising-edge history
  always_ff @(posedge clk_16mhz or negedge rst_n) begin
    if (!rst_n) begin
      fsync <= '0;
      es1   <= '0;
      es2   <= '0;
      eprev <= '0;
    end else begin
      fsync <= {fsync[0], bus.fast_mode};
      es1   <= {bus.zero_sec, bus.adv_hour,
                bus.adv_min};
      es2   <= es1;
      eprev <= es2;
    end
  end

  // Next time state: zero > hour/min set > tick
  always_comb begin
    lim    = fast_s ? FAST_LIM : SLOW_LIM;
    hit    = run && (presc >= lim);
    due    = hit || pend;
    sec_nx = (secs == 6'd59) ? 6'd0 : secs + 6'd1;
    min_nx = (mins == 6'd59) ? 6'd0 : mins + 6'd1;
    hr_nx  = (hrs == HW'(HOURS - 1)) ?
             '0 : hrs + HW'(1);
    n_presc = (!run || hit) ? '0 : presc + PW'(1);
    n_sec  = secs;
    n_min  = mins;
    n_hr   = hrs;
    n_pend = 1'b0;
    n_tick = 1'b0;
    if (ev[0]) n_min = min_nx;
    if (ev[1]) n_hr = hr_nx;
    if (ev[2]) begin
      n_sec   = '0;
      n_presc = '0;
    end else if (ev[0] || ev[1]) begin
      n_pend = due;
    end else if (due) begin
      n_tick = 1'b1;
      n_sec  = sec_nx;
      if (secs == 6'd59) begin
        n_min = min_nx;
        if (mins == 6'd59) n_hr = hr_nx;
      end
    end
  end

  // Time and prescaler registers
  always_ff @(posedge clk_16mhz or negedge rst_n) begin
    if (!rst_n) begin
      presc  <= '0;
      secs   <= '0;
      mins   <= '0;
      hrs    <= '0;
      pend   <= 1'b0;
      tick_r <= 1'b0;
    end else begin
      presc  <= n_presc;
      secs   <= n_sec;
      mins   <= n_min;
      hrs    <= n_hr;
      pend   <= n_pend;
      tick_r <= n_tick;
    end
  end

  // Slot timer walks sec -> min -> hour hands
  always_ff @(posedge clk_16mhz or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      slot_idx <= 2'd0;
    end else if (slot_cnt == SW'(SLOT_CYCLES - 1)) begin
      slot_cnt <= '0;
      slot_idx <= (slot_idx == 2'd2) ?
                  2'd0 : slot_idx + 2'd1;
    end else begin
      slot_cnt <= slot_cnt + SW'(1);
    end
  end

  // Hand position and colour for the active slot
  always_comb begin
    lit     = (slot_cnt >= SW'(BLANK_CYCLES));
    sec_pos = (32'(secs) * 32'(RING_LEDS)) / 32'd60;
    min_pos = (32'(mins) * 32'(RING_LEDS)) / 32'd60;
    hr_pos  = (((32'(hrs) % 32'd12) * 32'd60 +
                32'(mins)) * 32'(RING_LEDS)) / 32'd720;
    pos = hr_pos;
    col = COL_HOUR;
    unique case (1'b1)
      (slot_idx == 2'd0): begin
        pos = sec_pos;
        col = COL_SEC;
      end
      (slot_idx == 2'd1): begin
        pos = min_pos;
        col = COL_MIN;
      end
      default: begin
        pos = hr_pos;
        col = COL_HOUR;
      end
    endcase
  end

  // Registered ring outputs, dark during blanking
  always_ff @(posedge clk_16mhz or negedge rst_n) begin
    if (!rst_n) begin
      leds_q <= '0;
      col_q  <= '0;
      sel_q  <= 2'd3;
    end else if (lit) begin
      leds_q <= ONE << pos;
      col_q  <= col;
      sel_q  <= slot_idx;
    end else begin
      leds_q <= '0;
      col_q  <= '0;
      sel_q  <= 2'd3;
    end
  end

  assign bus.leds     = leds_q;
  assign bus.int_r    = col_q[23:16];
  assign bus.int_g    = col_q[15:8];
  assign bus.int_b    = col_q[7:0];
  assign bus.hand_sel = sel_q;
  assign bus.second   = secs;
  assign bus.minute   = mins;
  assign bus.hour     = hrs;
  assign bus.tick     = tick_r;

endmodule

// File: tb/tb_ring_clock_engine.sv
// Scoreboard bench for ring_clock_engine: three
// lockstep instances (60/12h, 12/12h, 60/24h).
module tb_ring_clock_engine;

  localparam int CLK_HZ = 100;
  localparam int FDIV   = 10;
  localparam int SLOT   = 8;
  localparam int BLANK  = 2;

  logic clk_16mhz = 1'b0;
  logic rst_n = 1'b0;
  logic fm = 1'b0;
  logic am = 1'b0;
  logic ah = 1'b0;
  logic zs = 1'b0;

  always #5 clk_16mhz = ~clk_16mhz;

  ring_clock_engine_if #(.RING_LEDS(60), .HOURS(12)) b0();
  ring_clock_engine_if #(.RING_LEDS(12), .HOURS(12)) b1();
  ring_clock_engine_if #(.RING_LEDS(60), .HOURS(24)) b2();

  assign b0.fast_mode = fm;
  assign b0.adv_min   = am;
  assign b0.adv_hour  = ah;
  assign b0.zero_sec  = zs;
  assign b1.fast_mode = fm;
  assign b1.adv_min   = am;
  assign b1.adv_hour  = ah;
  assign b1.zero_sec  = zs;
  assign b2.fast_mode = fm;
  assign b2.adv_min   = am;
  assign b2.adv_hour  = ah;
  assign b2.zero_sec  = zs;

  ring_clock_engine #(
    .CLK_HZ(CLK_HZ), .FAST_DIV(FDIV),
    .RING_LEDS(60), .HOURS(12),
    .SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)
  ) u0 (
    .clk_16mhz(clk_16mhz), .rst_n(rst_n), .bus(b0)
  );

  ring_clock_engine #(
    .CLK_HZ(CLK_HZ), .FAST_DIV(FDIV),
    .RING_LEDS(12), .HOURS(12),
    .SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)
  ) u1 (
    .clk_16mhz(clk_16mhz), .rst_n(rst_n), .bus(b1)
  );

  ring_clock_engine #(
    .CLK_HZ(CLK_HZ), .FAST_DIV(FDIV),
    .RING_LEDS(60), .HOURS(24),
    .SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)
  ) u2 (
    .clk_16mhz(clk_16mhz), .rst_n(rst_n), .bus(b2)
  );

  typedef struct {
    int s;
    int m;
    int h12;
    int h24;
  } tm_t;

  typedef struct {
    logic [1:0]  hs;
    logic [59:0] l60;
    logic [11:0] l12;
    logic [23:0] col;
  } fr_t;

  tm_t tick_q[$];
  fr_t fr_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ntick = 0;
  int tick_cyc = 0;
  int c_last = 0;
  int ms = 0;
  int mm = 0;
  int mh12 = 0;
  int mh24 = 0;
  bit armed = 1'b0;
  bit run_ok = 1'b0;
  int run_len = 0;
  logic prev_tick = 1'b0;
  logic [1:0] prev_hs = 2'd3;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  always @(posedge clk_16mhz) cyc <= cyc + 1;

  // Monitor: pops expected time on every tick,
  // expected frames on every slot start.
  always @(negedge clk_16mhz) begin
    tm_t e;
    fr_t f;
    logic [1:0] hs;
    if (rst_n) begin
      chk("onehot", {61'd0,
          $onehot0(b0.leds), $onehot0(b1.leds),
          $onehot0(b2.leds)}, 64'd7);
      if (b0.tick) begin
        if (prev_tick) chk("tick_width", 1, 0);
        if (tick_q.size() == 0) begin
          chk("tick_unexpected", 1, 0);
        end else begin
          e = tick_q.pop_front();
          chk("tick_sec", b0.second, e.s);
          chk("tick_min", b0.minute, e.m);
          chk("tick_hr12", b0.hour, e.h12);
          chk("tick_hr24", b2.hour, e.h24);
        end
        ntick++;
        tick_cyc = cyc;
      end
      prev_tick = b0.tick;
      hs = b0.hand_sel;
      if (armed) begin
        if (hs != prev_hs) begin
          if (run_ok) begin
            if (hs == 2'd3)
              chk("lit_len", run_len, SLOT - BLANK);
            else
              chk("blank_len", run_len, BLANK);
          end
          run_ok = 1'b1;
          run_len = 1;
          if (hs != 2'd3 && fr_q.size() > 0 &&
              fr_q[0].hs == hs) begin
            f = fr_q.pop_front();
            chk("fr_leds60", b0.leds, f.l60);
            chk("fr_leds12", b1.leds, f.l12);
            chk("fr_leds24h", b2.leds, f.l60);
            chk("fr_col", {b0.int_r, b0.int_g,
                b0.int_b}, f.col);
          end
        end else begin
          run_len++;
        end
        if (hs == 2'd3) begin
          chk("dark_leds", b0.leds, 0);
          chk("dark_col", {b0.int_r, b0.int_g,
              b0.int_b}, 0);
        end
      end
      prev_hs = hs;
    end
  end

  task automatic step();
    @(negedge clk_16mhz);
    #1;
  endtask

  task automatic push_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      ms = (ms == 59) ? 0 : ms + 1;
      if (ms == 0) begin
        mm = (mm == 59) ? 0 : mm + 1;
        if (mm == 0) begin
          mh12 = (mh12 + 1) % 12;
          mh24 = (mh24 + 1) % 24;
        end
      end
      tick_q.push_back('{ms, mm, mh12, mh24});
    end
  endtask

  task automatic pulse(input bit z, input bit m,
                       input bit h);
    zs = z;
    am = m;
    ah = h;
    c_last = cyc;
    repeat (4) step();
    zs = 1'b0;
    am = 1'b0;
    ah = 1'b0;
    repeat (4) step();
    if (z) ms = 0;
    if (m) mm = (mm + 1) % 60;
    if (h) begin
      mh12 = (mh12 + 1) % 12;
      mh24 = (mh24 + 1) % 24;
    end
  endtask

  task automatic wait_ticks(input int target,
                            input int bound,
                            input string nm);
    int k;
    k = 0;
    while (ntick < target && k < bound) begin
      step();
      k++;
    end
    chk(nm, ntick, target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int rel;
    int t;
    int c;
    int k;
    logic [59:0] l60;
    logic [11:0] l12;

    repeat (3) step();
    chk("rst_sec", b0.second, 0);
    chk("rst_min", b0.minute, 0);
    chk("rst_hour", b0.hour, 0);
    chk("rst_leds", b0.leds, 0);
    chk("rst_col", {b0.int_r, b0.int_g, b0.int_b}, 0);
    chk("rst_sel", b0.hand_sel, 3);
    chk("rst_tick", b0.tick, 0);

    push_ticks(2);
    rel = cyc;
    rst_n = 1'b1;
    wait_ticks(1, 300, "first_tick");
    t = tick_cyc;
    chk("first_tick_lat",
        (t - rel >= 100 && t - rel <= 102), 1);
    wait_ticks(2, 300, "second_tick");
    chk("slow_period", tick_cyc - t, 100);

    fm = 1'b1;
    push_ticks(2);
    wait_ticks(3, 100, "fast_tick_a");
    t = tick_cyc;
    wait_ticks(4, 100, "fast_tick_b");
    chk("fast_period", tick_cyc - t, 10);

    repeat (23) pulse(1, 1, 1);
    repeat (36) pulse(1, 1, 0);
    chk("preset_sec", b0.second, 0);
    chk("preset_min", b0.minute, 59);
    chk("preset_hr12", b0.hour, 11);
    chk("preset_hr24", b2.hour, 23);
    push_ticks(60);
    wait_ticks(64, 800, "wrap_ticks");
    chk("wrap_hr12", b0.hour, 0);
    chk("wrap_hr24", b2.hour, 0);

    repeat (10) pulse(1, 1, 0);
    c = c_last;
    push_ticks(59);
    while (cyc < c + 600) step();
    am = 1'b1;
    mm = 11;
    push_ticks(1);
    while (cyc < c + 603) step();
    chk("coinc_min", b0.minute, 11);
    chk("coinc_sec", b0.second, 59);
    chk("coinc_tick", b0.tick, 0);
    chk("coinc_hour", b0.hour, 0);
    am = 1'b0;
    wait_ticks(124, 100, "coinc_ticks");

    push_ticks(37);
    wait_ticks(161, 600, "to_37");
    t = tick_cyc;
    fm = 1'b0;
    while (cyc < t + 58) step();
    zs = 1'b1;
    am = 1'b1;
    c = cyc;
    ms = 0;
    mm = 13;
    push_ticks(1);
    while (cyc < c + 3) step();
    chk("zero_sec", b0.second, 0);
    chk("zero_adv_min", b0.minute, 13);
    step();
    zs = 1'b0;
    am = 1'b0;
    wait_ticks(162, 200, "zero_tick");
    chk("zero_period", tick_cyc - (c + 3), 100);

    repeat (3) pulse(1, 1, 1);
    repeat (8) pulse(1, 1, 0);
    fm = 1'b1;
    push_ticks(45);
    wait_ticks(207, 700, "to_3_24_45");
    fm = 1'b0;
    chk("t_hour", b0.hour, 3);
    chk("t_min", b0.minute, 24);
    chk("t_sec", b0.second, 45);
    l60 = 60'd1 << 45;
    l12 = 12'd1 << 9;
    fr_q.push_back('{2'd0, l60, l12, 24'h8C0CFF});
    l60 = 60'd1 << 24;
    l12 = 12'd1 << 4;
    fr_q.push_back('{2'd1, l60, l12, 24'hFF4019});
    l60 = 60'd1 << 17;
    l12 = 12'd1 << 3;
    fr_q.push_back('{2'd2, l60, l12, 24'hC8C800});
    armed = 1'b1;
    k = 0;
    while (fr_q.size() > 0 && k < 80) begin
      step();
      k++;
    end
    chk("frames_done", fr_q.size(), 0);
    armed = 1'b0;

    k = 0;
    while (b0.hand_sel == 2'd3 && k < 20) begin
      step();
      k++;
    end
    chk("pre_rst_lit", (b0.leds != 0), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_leds", b0.leds, 0);
    chk("arst_col", {b0.int_r, b0.int_g, b0.int_b}, 0);
    chk("arst_sel", b0.hand_sel, 3);
    chk("arst_sec", b0.second, 0);
    chk("arst_min", b0.minute, 0);
    chk("arst_hour", b0.hour, 0);
    chk("arst_hr24", b2.hour, 0);
    chk("tick_q_empty", tick_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
